// File: rtl/gauss_pkg.sv
// Shared constants and types for the Gaussian blur front-end sequencer.
package gauss_pkg;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int KSIZE  = 11;
  localparam int H      = KSIZE / 2;

  localparam logic [1:0] FILT_BYPASS  = 2'b00;
  localparam logic [1:0] FILT_GAUSS3  = 2'b01;
  localparam logic [1:0] FILT_GAUSS5  = 2'b10;
  localparam logic [1:0] FILT_GAUSS11 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2,
    S_HBLANK = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Registers one sync input once and reports rise/fall against the registered copy.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_r;

  // one-stage history of the sync input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r <= 1'b0;
    end else begin
      sig_r <= sig;
    end
  end

  // edge pulses relative to the previous cycle
  always_comb begin
    rise = sig & ~sig_r;
    fall = ~sig & sig_r;
  end

endmodule

// File: rtl/gauss_line_ctrl.sv
// Turns DE/VS framed camera pixels into column index, buffer-write strobe,
// line-shift pulse and window-valid flag for the blur window.
module gauss_line_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int KSIZE  = 11,
  parameter int COL_W  = 13,
  parameter int ROW_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vs,
  input  logic             in_de,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  input  logic [1:0]       filt_sel_in,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic [COL_W-1:0] col,
  output logic             buff_en,
  output logic             shift_en,
  output logic [1:0]       filt_sel,
  output logic [ROW_W-1:0] row,
  output logic             win_valid,
  output logic             line_err
);
  import gauss_pkg::*;

  localparam int               HALF     = KSIZE / 2;
  localparam logic [COL_W-1:0] WIDTH_C  = COL_W'(WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [COL_W-1:0] LO_COL   = COL_W'(HALF);
  localparam logic [COL_W-1:0] HI_COL   = COL_W'(WIDTH - 1 - HALF);
  localparam logic [COL_W-1:0] CNT_MAX  = {COL_W{1'b1}};
  localparam logic [ROW_W-1:0] HEIGHT_C = ROW_W'(HEIGHT);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(KSIZE - 1);

  state_t           state_r, state_nxt_s;
  logic             vs_rise_s, vs_fall_unused_s, de_rise_s, de_fall_s;
  logic             accept_s, line_end_s, in_range_s;
  logic [COL_W-1:0] pix_cnt_r, cnt_now_s;

  sync_edge u_vs_edge (.clk(clk), .rst(rst), .sig(in_vs), .rise(vs_rise_s), .fall(vs_fall_unused_s));
  sync_edge u_de_edge (.clk(clk), .rst(rst), .sig(in_de), .rise(de_rise_s), .fall(de_fall_s));

  // pixel acceptance: a new line only starts on a DE rise seen in a blanking state
  always_comb begin
    accept_s   = in_de & ~vs_rise_s &
                 ((state_r == S_ACTIVE) |
                  (de_rise_s & ((state_r == S_VBLANK) | (state_r == S_HBLANK))));
    cnt_now_s  = (state_r == S_ACTIVE) ? pix_cnt_r : {COL_W{1'b0}};
    in_range_s = (cnt_now_s < WIDTH_C);
    line_end_s = de_fall_s & (state_r == S_ACTIVE) & ~vs_rise_s;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state: a VS rise restarts the frame from any non-idle point
  always_comb begin
    state_nxt_s = state_r;
    if (vs_rise_s) begin
      state_nxt_s = S_VBLANK;
    end else begin
      case (state_r)
        S_IDLE:   state_nxt_s = S_IDLE;
        S_VBLANK: state_nxt_s = de_rise_s ? S_ACTIVE : S_VBLANK;
        S_ACTIVE: state_nxt_s = de_fall_s ? S_HBLANK : S_ACTIVE;
        S_HBLANK: state_nxt_s = de_rise_s ? S_ACTIVE : S_HBLANK;
        default:  state_nxt_s = S_IDLE;
      endcase
    end
  end

  // pixel path, line counters and frame-level latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r         <= 8'd0;
      g         <= 8'd0;
      b         <= 8'd0;
      col       <= {COL_W{1'b0}};
      buff_en   <= 1'b0;
      shift_en  <= 1'b0;
      filt_sel  <= 2'b00;
      row       <= {ROW_W{1'b0}};
      win_valid <= 1'b0;
      line_err  <= 1'b0;
      pix_cnt_r <= {COL_W{1'b0}};
    end else begin
      buff_en   <= 1'b0;
      shift_en  <= 1'b0;
      win_valid <= 1'b0;
      line_err  <= 1'b0;
      if (vs_rise_s) begin
        row       <= {ROW_W{1'b0}};
        filt_sel  <= filt_sel_in;
        pix_cnt_r <= {COL_W{1'b0}};
      end
      if (accept_s) begin
        r         <= in_r;
        g         <= in_g;
        b         <= in_b;
        col       <= in_range_s ? cnt_now_s : LAST_COL;
        buff_en   <= in_range_s;
        win_valid <= in_range_s & (row >= ROW_MIN) &
                     (cnt_now_s >= LO_COL) & (cnt_now_s <= HI_COL);
        // count keeps running past WIDTH so overruns are visible at line end
        pix_cnt_r <= (cnt_now_s == CNT_MAX) ? cnt_now_s : cnt_now_s + {{(COL_W-1){1'b0}}, 1'b1};
      end
      if (line_end_s) begin
        shift_en <= 1'b1;
        line_err <= (pix_cnt_r != WIDTH_C);
        if (row < HEIGHT_C) begin
          row <= row + {{(ROW_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_gauss_line_ctrl.sv
// Scoreboard bench for gauss_line_ctrl on a reduced 32x14 frame.
module tb_gauss_line_ctrl;

  localparam int W  = 32;
  localparam int HT = 14;
  localparam int K  = 11;
  localparam int HW = K / 2;

  logic        clk, rst, in_vs, in_de;
  logic [7:0]  in_r, in_g, in_b, r, g, b;
  logic [1:0]  filt_sel_in, filt_sel;
  logic [12:0] col;
  logic [9:0]  row;
  logic        buff_en, shift_en, win_valid, line_err;

  typedef struct packed {logic [12:0] col; logic [23:0] rgb; logic win;} wr_t;
  typedef struct packed {logic [9:0] row; logic err; logic [1:0] filt;} sh_t;

  wr_t wr_q[$];
  sh_t sh_q[$];
  wr_t wr_e;
  sh_t sh_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  row_m    = 0;
  logic [1:0] filt_m = 2'b00;
  bit  mon_en = 1'b0;

  gauss_line_ctrl #(.WIDTH(W), .HEIGHT(HT), .KSIZE(K), .COL_W(13), .ROW_W(10)) dut (
    .clk(clk), .rst(rst), .in_vs(in_vs), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .filt_sel_in(filt_sel_in),
    .r(r), .g(g), .b(b), .col(col), .buff_en(buff_en), .shift_en(shift_en),
    .filt_sel(filt_sel), .row(row), .win_valid(win_valid), .line_err(line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int n, input int gap, input bit expect_out);
    logic [23:0] px;
    for (int i = 0; i < n; i++) begin
      step();
      px = 24'($urandom);
      in_de = 1'b1;
      {in_r, in_g, in_b} = px;
      if (expect_out && i < W)
        wr_q.push_back('{col: 13'(i), rgb: px,
                         win: (row_m >= K-1) && (i >= HW) && (i <= W-1-HW)});
      if (expect_out && i >= W + 1) begin
        check_eq("ovr_col", 32'(col), 32'(W - 1));
        check_eq("ovr_buff_en", 32'(buff_en), 32'd0);
      end
    end
    step();
    in_de = 1'b0;
    if (expect_out) begin
      row_m = (row_m < HT) ? row_m + 1 : HT;
      sh_q.push_back('{row: 10'(row_m), err: (n != W), filt: filt_m});
    end
    repeat (gap) step();
  endtask

  task automatic vsync(input logic [1:0] sel);
    step();
    in_de = 1'b0;
    in_vs = 1'b1;
    filt_sel_in = sel;
    repeat (2) step();
    in_vs = 1'b0;
    row_m = 0;
    filt_m = sel;
    repeat (3) step();
    check_eq("vs_filt", 32'(filt_sel), 32'(sel));
    check_eq("vs_row", 32'(row), 32'd0);
  endtask

  // transaction monitor: every strobe must match the head of its queue
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check_eq("excl_buff_shift", 32'(buff_en & shift_en), 32'd0);
      check_eq("win_wo_buff", 32'(win_valid & ~buff_en), 32'd0);
      check_eq("err_wo_shift", 32'(line_err & ~shift_en), 32'd0);
      if (buff_en) begin
        if (wr_q.size() == 0) begin
          check_eq("wr_unexpected", 32'(buff_en), 32'd0);
        end else begin
          wr_e = wr_q.pop_front();
          check_eq("wr_col", 32'(col), 32'(wr_e.col));
          check_eq("wr_rgb", 32'({r, g, b}), 32'(wr_e.rgb));
          check_eq("wr_win", 32'(win_valid), 32'(wr_e.win));
        end
      end
      if (shift_en) begin
        if (sh_q.size() == 0) begin
          check_eq("sh_unexpected", 32'(shift_en), 32'd0);
        end else begin
          sh_e = sh_q.pop_front();
          check_eq("sh_row", 32'(row), 32'(sh_e.row));
          check_eq("sh_err", 32'(line_err), 32'(sh_e.err));
          check_eq("sh_filt", 32'(filt_sel), 32'(sh_e.filt));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_vs = 1'b0; in_de = 1'b0;
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0; filt_sel_in = 2'b00;
    repeat (3) step();
    check_eq("rst_buff_en", 32'(buff_en), 32'd0);
    check_eq("rst_shift_en", 32'(shift_en), 32'd0);
    check_eq("rst_row", 32'(row), 32'd0);
    check_eq("rst_col", 32'(col), 32'd0);
    check_eq("rst_filt", 32'(filt_sel), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // DE lines before any VS must be ignored
    drive_line(W, 4, 1'b0);
    drive_line(W, 4, 1'b0);

    // two full frames, including lines beyond HEIGHT
    for (int f = 0; f < 2; f++) begin
      vsync(2'b10);
      for (int l = 0; l < HT + 2; l++) drive_line(W, 4, 1'b1);
      check_eq("frame_row_sat", 32'(row), 32'(HT));
    end

    // filter mode only follows the request at a VS edge
    vsync(2'b01);
    for (int l = 0; l < 3; l++) drive_line(W, 4, 1'b1);
    filt_sel_in = 2'b10;
    for (int l = 0; l < 3; l++) drive_line(W, 4, 1'b1);
    check_eq("filt_hold", 32'(filt_sel), 32'b01);
    vsync(2'b10);

    // short and long lines
    drive_line(W - 8, 4, 1'b1);
    drive_line(W + 20, 4, 1'b1);
    drive_line(W, 4, 1'b1);

    // VS rise together with DE high: that line is dropped
    step();
    in_vs = 1'b1; in_de = 1'b1;
    repeat (2) step();
    in_vs = 1'b0;
    row_m = 0; filt_m = filt_sel_in;
    repeat (12) step();
    in_de = 1'b0;
    repeat (4) step();
    check_eq("coinc_row", 32'(row), 32'd0);
    drive_line(W, 4, 1'b1);
    check_eq("coinc_next_row", 32'(row), 32'd1);

    // reset in the middle of an accepted line
    vsync(2'b11);
    mon_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      in_de = 1'b1;
      {in_r, in_g, in_b} = 24'($urandom);
    end
    rst = 1'b1;
    #1;
    check_eq("midrst_buff_en", 32'(buff_en), 32'd0);
    check_eq("midrst_col", 32'(col), 32'd0);
    check_eq("midrst_rgb", 32'({r, g, b}), 32'd0);
    check_eq("midrst_filt", 32'(filt_sel), 32'd0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (8) step();
    in_de = 1'b0;
    repeat (4) step();
    row_m = 0;
    drive_line(W, 4, 1'b0);
    vsync(2'b01);
    drive_line(W, 4, 1'b1);
    check_eq("post_rst_row", 32'(row), 32'd1);

    repeat (4) step();
    check_eq("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check_eq("sh_q_drained", 32'(sh_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gauss_line_ctrl.md
Name: gauss_line_ctrl

Overview:
- Front-end sequencer for the Gaussian blur stage in the D8M camera path.
- Converts the raw camera pixel stream (DE/VS framed RGB) into the column index, buffer-write strobe, line-shift pulse and registered RGB that the 11x11 blur window consumes.
- Tracks line and row position, latches the filter mode once per frame, and flags when the window holds a fully valid neighbourhood.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- KSIZE, 11, kernel height/width in lines/pixels; half-width H = KSIZE/2 = 5.
- COL_W, 13, width of column index.
- ROW_W, 10, width of row counter.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- in_vs  in  1  vertical sync, active high; rising edge = frame start
- in_de  in  1  data enable, high during active pixels of a line
- in_r, in_g, in_b  in  8 each  camera pixel
- filt_sel_in  in  2  requested filter mode
- r, g, b  out  8 each  registered pixel to the window buffer
- col  out  COL_W  column index of r/g/b
- buff_en  out  1  write r/g/b into line buffer at col
- shift_en  out  1  one-cycle pulse: shift line buffer into window rows
- filt_sel  out  2  filter mode, stable for the whole frame
- row  out  ROW_W  lines shifted this frame, saturating at HEIGHT
- win_valid  out  1  current col/row has a full KSIZE x KSIZE neighbourhood
- line_err  out  1  one-cycle pulse: completed line length != WIDTH

Behaviour:
- Reset: all outputs 0, FSM to S_IDLE; the partial frame in progress is discarded. Reset asserted mid-line gives the same result.
- Edge detect: in_vs and in_de are registered once; edges are detected against the registered value.
- S_IDLE -> S_VBLANK on the in_vs rising edge. in_de is ignored in S_IDLE.
- S_VBLANK -> S_ACTIVE on the in_de rising edge.
- S_ACTIVE -> S_HBLANK on the in_de falling edge.
- S_HBLANK -> S_ACTIVE on the in_de rising edge.
- From any state except S_IDLE -> S_VBLANK on the in_vs rising edge.
- vs rising edge actions: row <= 0, filt_sel <= filt_sel_in, pixel counter cleared.
- vs edge and de high in the same cycle: the vs edge wins, and that line is ignored until in_de falls.
- Pixel path latency is 1 cycle. When the FSM is active and in_de=1, on the next cycle:
  - r/g/b = input pixel
  - col = pixel count within the line, starting at 0
  - buff_en = 1 if count < WIDTH
- Overrun pixels (count >= WIDTH): buff_en=0, col holds WIDTH-1, and the count keeps running for the error check.
- Outside active pixels: buff_en=0; r/g/b and col hold their last values.
- shift_en pulses exactly 1 cycle, on the cycle after the in_de falling edge (in S_ACTIVE), for every line including short ones. It is never asserted together with buff_en.
- line_err pulses in the same cycle as shift_en if the pixel count != WIDTH.
- row increments with each shift_en and saturates at HEIGHT. Lines after HEIGHT still shift but do not increment row.
- win_valid = buff_en && row >= KSIZE-1 && H <= col <= WIDTH-1-H, registered aligned with col.
  - Example: row 10, col 5..634 -> win_valid=1.
  - Example: col 4 or col 635 -> 0.
- No back-pressure: the downstream stage accepts every strobe.

Decomposition:
- Shared package gauss_pkg holds:
  - WIDTH, HEIGHT, KSIZE and the derived H
  - filter-mode encoding constants
  - FSM state enum {S_IDLE, S_VBLANK, S_ACTIVE, S_HBLANK}
- One natural sub-module: sync_edge, which registers one sync input and outputs rise/fall pulses. It is instantiated for in_vs and for in_de.
- The counters and FSM stay in the top level.

Test Plan:
- Reset then 3 frames of 640x480, filt_sel_in=2'b10 -> buff_en high 640 cycles per line; col 0..639; 480 shift_en pulses per frame; row ends at 480; filt_sel=2'b10; no line_err.
- filt_sel_in changed from 01 to 10 mid-frame -> filt_sel stays 01 until the next vs rising edge, then becomes 10.
- Line of 600 pixels, then line of 700 pixels -> both produce shift_en and line_err. The 700-pixel line has buff_en high only 640 cycles, and col holds 639 for the last 60 cycles.
- Check win_valid across frame -> 0 for rows 0..9; at row 10 it is 1 exactly for col 5..634; it is never 1 when buff_en=0.
- DE active before the first vs after reset -> no buff_en/shift_en until the vs edge. Then assert rst mid-line -> all outputs 0 immediately, and the rest of the line is ignored until the next vs.
- in_vs rise coincident with in_de high -> that line produces no buff_en and no shift_en; row=0; the next full line gives row=1.
